// File: rtl/apb_arbiter2.sv
// Two-requester round-robin APB arbiter sharing one APB completer port.
// Optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter2 #(
  parameter int          ADDR_WIDTH     = 16,
  parameter int          DATA_WIDTH     = 16,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd64
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  m0_psel,
  input  logic                  m0_penable,
  input  logic                  m0_pwrite,
  input  logic [ADDR_WIDTH-1:0] m0_paddr,
  input  logic [DATA_WIDTH-1:0] m0_pwdata,
  output logic                  m0_pready,
  output logic [DATA_WIDTH-1:0] m0_prdata,
  input  logic                  m1_psel,
  input  logic                  m1_penable,
  input  logic                  m1_pwrite,
  input  logic [ADDR_WIDTH-1:0] m1_paddr,
  input  logic [DATA_WIDTH-1:0] m1_pwdata,
  output logic                  m1_pready,
  output logic [DATA_WIDTH-1:0] m1_prdata,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  output logic [1:0]            grant,
  output logic                  timeout_err,
  output logic [1:0]            state_dbg
);

  // Handshake: a requester asserts psel and holds its controls stable until
  // it sees one cycle of its pready; the shared side follows APB SETUP/ACCESS
  // and completes on PENABLE & PREADY.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state;
  logic                  last_m1;
  logic                  pick_m1;
  logic                  fin;
  logic                  tmo_hit;
  logic [DATA_WIDTH-1:0] fin_data;
  logic                  penable_unused;

  assign state_dbg      = state;
  assign penable_unused = m0_penable | m1_penable;

  // On a tie, the requester that did not win last time is served.
  assign pick_m1 = m1_psel && (!m0_psel || !last_m1);

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  always_comb begin
    tmo_hit = 1'b0;
    if (state == ACCESS && !PREADY && tmo_cnt == TIMEOUT_CYCLES - 8'd1)
      tmo_hit = 1'b1;
  end
`else
  logic [7:0] tmo_unused;

  assign tmo_unused  = TIMEOUT_CYCLES;
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    fin      = (state == ACCESS) && (PREADY || tmo_hit);
    fin_data = PREADY ? PRDATA : {DATA_WIDTH{1'b1}};
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      last_m1   <= 1'b1;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      m0_pready <= 1'b0;
      m1_pready <= 1'b0;
      m0_prdata <= '0;
      m1_prdata <= '0;
      grant     <= 2'b00;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      m0_pready <= 1'b0;
      m1_pready <= 1'b0;
      m0_prdata <= '0;
      m1_prdata <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (m0_psel || m1_psel) begin
            grant   <= pick_m1 ? 2'b10 : 2'b01;
            last_m1 <= pick_m1;
            PWRITE  <= pick_m1 ? m1_pwrite : m0_pwrite;
            PADDR   <= pick_m1 ? m1_paddr  : m0_paddr;
            PWDATA  <= pick_m1 ? m1_pwdata : m0_pwdata;
            PSEL    <= 1'b1;
            state   <= SETUP;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (fin) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state   <= DONE;
            if (grant[1]) begin
              m1_pready <= 1'b1;
              m1_prdata <= fin_data;
            end else begin
              m0_pready <= 1'b1;
              m0_prdata <= fin_data;
            end
`ifdef APB_ARB_TIMEOUT_EN
            timeout_err <= tmo_hit;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
`endif
          end
        end
        DONE: begin
          grant <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter2.sv
// Bench for apb_arbiter2: directed protocol steps plus randomized traffic
// against a transaction-level model of the two requesters and the completer.
module tb_apb_arbiter2;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        m0_psel = 1'b0, m0_penable = 1'b0, m0_pwrite = 1'b0;
  logic [15:0] m0_paddr = '0, m0_pwdata = '0;
  logic        m1_psel = 1'b0, m1_penable = 1'b0, m1_pwrite = 1'b0;
  logic [15:0] m1_paddr = '0, m1_pwdata = '0;
  logic        m0_pready, m1_pready;
  logic [15:0] m0_prdata, m1_prdata;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  logic [15:0] PADDR, PWDATA, PRDATA;
  logic [1:0]  grant, state_dbg;
  logic        timeout_err;

  apb_arbiter2 #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT_CYCLES(8'd8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pready(m0_pready), .m0_prdata(m0_prdata),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pready(m1_pready), .m1_prdata(m1_prdata),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA),
    .grant(grant), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- completer model ----------------
  logic [15:0] cmem [16];
  int          acc_cnt = 0;
  int          wait_n = 0;
  int          wait_r = 0;
  bit          rand_wait = 1'b0;
  bit          stall = 1'b0;

  initial for (int i = 0; i < 16; i++) cmem[i] <= 16'hA5A0 | 16'(i);

  assign PREADY = PSEL && PENABLE && !stall && (acc_cnt >= (rand_wait ? wait_r : wait_n));
  assign PRDATA = cmem[PADDR[3:0]];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY) begin
      if (PWRITE) cmem[PADDR[3:0]] <= PWDATA;
      acc_cnt <= 0;
      wait_r  <= $urandom_range(0, 3);
    end else if (PSEL && PENABLE) begin
      acc_cnt <= acc_cnt + 1;
    end else begin
      acc_cnt <= 0;
    end
  end

  // ---------------- reference model / scoreboard state ----------------
  logic [15:0] mm [16];
  logic [32:0] txq0[$], txq1[$];
  logic [15:0] exp_q0[$], exp_q1[$];
  logic [1:0]  glog[$];
  bit          agents_on = 1'b0, gap_en = 1'b0;
  bit          busy0 = 1'b0, busy1 = 1'b0, done0 = 1'b0, done1 = 1'b0;
  logic [32:0] t_ag;

  initial for (int i = 0; i < 16; i++) mm[i] = 16'hA5A0 | 16'(i);

  // A transfer returns the completer's current word (old value for writes).
  task automatic enq(input int r, input bit w, input logic [15:0] a, input logic [15:0] d);
    logic [32:0] t;
    logic [3:0]  ix;
    t  = {w, a, d};
    ix = a[3:0];
    if (r == 0) begin txq0.push_back(t); exp_q0.push_back(mm[ix]); end
    else        begin txq1.push_back(t); exp_q1.push_back(mm[ix]); end
    if (w) mm[ix] = d;
  endtask

  // ---------------- requester drivers ----------------
  always @(posedge PCLK) begin
    #1;
    if (agents_on) begin
      if (busy0 && done0) begin busy0 = 1'b0; done0 = 1'b0; end
      if (!busy0 && txq0.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
        t_ag = txq0.pop_front();
        m0_psel = 1'b1; m0_penable = 1'b0; m0_pwrite = t_ag[32];
        m0_paddr = t_ag[31:16]; m0_pwdata = t_ag[15:0]; busy0 = 1'b1;
      end else if (!busy0) begin
        m0_psel = 1'b0; m0_penable = 1'b0;
      end else m0_penable = 1'b1;
      if (busy1 && done1) begin busy1 = 1'b0; done1 = 1'b0; end
      if (!busy1 && txq1.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
        t_ag = txq1.pop_front();
        m1_psel = 1'b1; m1_penable = 1'b0; m1_pwrite = t_ag[32];
        m1_paddr = t_ag[31:16]; m1_pwdata = t_ag[15:0]; busy1 = 1'b1;
      end else if (!busy1) begin
        m1_psel = 1'b0; m1_penable = 1'b0;
      end else m1_penable = 1'b1;
    end
  end

  // ---------------- monitor: arbitration rule, isolation, scoreboard ----------------
  logic [1:0] gprev = 2'b00, pselprev = 2'b00, expg;
  bit         last1 = 1'b1;

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      last1 = 1'b1; gprev = 2'b00; pselprev = {m1_psel, m0_psel};
    end else begin
      if (gprev == 2'b00 && grant != 2'b00) begin
        expg = (pselprev == 2'b11) ? (last1 ? 2'b01 : 2'b10) : pselprev;
        chk("arb_pick", grant, expg);
        chk("setup_phase", {PSEL, PENABLE}, 2'b10);
        chk("setup_paddr", PADDR, grant[1] ? m1_paddr : m0_paddr);
        chk("setup_pwdata", PWDATA, grant[1] ? m1_pwdata : m0_pwdata);
        last1 = grant[1];
        glog.push_back(grant);
      end
      if (!grant[0]) chk("m0_isolated", {m0_pready, m0_prdata}, 17'h0);
      if (!grant[1]) chk("m1_isolated", {m1_pready, m1_prdata}, 17'h0);
      if (agents_on && m0_pready) begin
        chk("m0_pready_expected", {busy0, exp_q0.size() > 0}, 2'b11);
        if (exp_q0.size() > 0) chk("m0_prdata", m0_prdata, exp_q0.pop_front());
        done0 = 1'b1;
      end
      if (agents_on && m1_pready) begin
        chk("m1_pready_expected", {busy1, exp_q1.size() > 0}, 2'b11);
        if (exp_q1.size() > 0) chk("m1_prdata", m1_prdata, exp_q1.pop_front());
        done1 = 1'b1;
      end
      gprev = grant;
      pselprev = {m1_psel, m0_psel};
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("rst_psel_penable_pwrite", {PSEL, PENABLE, PWRITE}, 3'b000);
    chk("rst_paddr_pwdata", {PADDR, PWDATA}, 32'h0);
    chk("rst_pready", {m0_pready, m1_pready}, 2'b00);
    chk("rst_prdata", {m0_prdata, m1_prdata}, 32'h0);
    chk("rst_grant_tmo", {grant, timeout_err}, 3'b000);
    chk("rst_state", state_dbg, 2'd0);
    PRESETn = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((txq0.size() > 0 || txq1.size() > 0 || busy0 || busy1) && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    chk({tag, "_drain_timeout"}, n >= budget, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random steps ----------------
  initial begin
    int np;

    do_reset();

    // Single M0 write, zero-wait completer: PSEL c1, PENABLE c2, pready c3.
    wait_n = 0;
    @(posedge PCLK); #1;
    m0_psel = 1'b1; m0_penable = 1'b0; m0_pwrite = 1'b1; m0_paddr = 16'h0002; m0_pwdata = 16'h1234;
    @(negedge PCLK);
    chk("t1_c0_psel", PSEL, 1'b0);
    @(posedge PCLK); #1; m0_penable = 1'b1;
    @(negedge PCLK);
    chk("t1_c1_sel_en", {PSEL, PENABLE, PWRITE}, 3'b101);
    chk("t1_c1_addr_data", {PADDR, PWDATA}, {16'h0002, 16'h1234});
    chk("t1_c1_grant", grant, 2'b01);
    @(negedge PCLK);
    chk("t1_c2_sel_en", {PSEL, PENABLE}, 2'b11);
    chk("t1_c2_pready", m0_pready, 1'b0);
    @(negedge PCLK);
    chk("t1_c3_pready", {m0_pready, m1_pready}, 2'b10);
    chk("t1_c3_prdata", m0_prdata, mm[2]);
    chk("t1_c3_psel", {PSEL, PENABLE}, 2'b00);
    @(posedge PCLK); #1;
    m0_psel = 1'b0; m0_penable = 1'b0; mm[2] = 16'h1234;
    @(negedge PCLK);
    chk("t1_c4_idle", {grant, m0_pready}, 3'b000);
    chk("t1_c4_hold_addr", {PADDR, PWDATA, PWRITE}, {16'h0002, 16'h1234, 1'b1});

    // M1 read with three completer wait cycles.
    wait_n = 3; np = 0;
    @(posedge PCLK); #1;
    m1_psel = 1'b1; m1_penable = 1'b0; m1_pwrite = 1'b0; m1_paddr = 16'h0005; m1_pwdata = 16'h0;
    for (int c = 0; c <= 6; c++) begin
      @(negedge PCLK);
      if (c >= 1) chk("t2_grant", grant, 2'b10);
      if (m1_pready) begin
        np++;
        chk("t2_pready_cycle", c, 6);
        chk("t2_prdata", m1_prdata, 16'hA5A5);
      end
      m1_penable = (c >= 1);
    end
    @(posedge PCLK); #1; m1_psel = 1'b0; m1_penable = 1'b0;
    @(negedge PCLK);
    chk("t2_pready_count", np, 1);
    chk("t2_grant_cleared", grant, 2'b00);

    // Tie out of reset, both held for four transfers: M0, M1, M0, M1.
    do_reset();
    wait_n = 0; glog.delete();
    enq(0, 1'b1, 16'h0000, 16'h1111); enq(0, 1'b0, 16'h0004, 16'h0);
    enq(1, 1'b1, 16'h0001, 16'h2222); enq(1, 1'b0, 16'h0003, 16'h0);
    agents_on = 1'b1; gap_en = 1'b0;
    wait_idle(200, "t3");
    chk("t3_count", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("t3_order0", glog[0], 2'b01);
      chk("t3_order1", glog[1], 2'b10);
      chk("t3_order2", glog[2], 2'b01);
      chk("t3_order3", glog[3], 2'b10);
    end

    // M0 back-to-back, M1 arrives mid-transfer: M0, M1, M0.
    glog.delete(); wait_n = 2;
    enq(0, 1'b1, 16'h0006, 16'h3333); enq(0, 1'b0, 16'h0006, 16'h0);
    repeat (3) @(negedge PCLK);
    enq(1, 1'b0, 16'h0007, 16'h0);
    wait_idle(200, "t4");
    chk("t4_count", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("t4_order0", glog[0], 2'b01);
      chk("t4_order1", glog[1], 2'b10);
      chk("t4_order2", glog[2], 2'b01);
    end
    agents_on = 1'b0;

    // Reset during ACCESS: outputs drop at once, pending request restarts.
    wait_n = 5; np = 0;
    @(posedge PCLK); #1;
    m0_psel = 1'b1; m0_penable = 1'b0; m0_pwrite = 1'b0; m0_paddr = 16'h0008;
    repeat (3) @(negedge PCLK);
    chk("t5_in_access", {PSEL, PENABLE, grant}, 4'b1101);
    #2 PRESETn = 1'b0;
    #1;
    chk("t5_async_drop", {PSEL, PENABLE, grant}, 4'b0000);
    chk("t5_no_pready", {m0_pready, m1_pready}, 2'b00);
    wait_n = 0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("t5_restart_setup", {PSEL, PENABLE, grant}, 4'b1001);
    @(negedge PCLK);
    chk("t5_restart_access", {PSEL, PENABLE}, 2'b11);
    @(negedge PCLK);
    chk("t5_done_pready", m0_pready, 1'b1);
    chk("t5_done_prdata", m0_prdata, mm[8]);
    @(posedge PCLK); #1; m0_psel = 1'b0;
    @(negedge PCLK);
    chk("t5_idle", grant, 2'b00);

    // Randomized traffic on disjoint address sets (M0 even, M1 odd).
    rand_wait = 1'b1; gap_en = 1'b1; agents_on = 1'b1;
    for (int i = 0; i < 30; i++) begin
      enq(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7) * 2), 16'($urandom));
      enq(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7) * 2 + 1), 16'($urandom));
    end
    wait_idle(3000, "t6");
    chk("t6_exp_empty", exp_q0.size() + exp_q1.size(), 0);
    agents_on = 1'b0; rand_wait = 1'b0;

`ifdef APB_ARB_TIMEOUT_EN
    // PREADY never comes: eight ACCESS cycles, then forced completion.
    stall = 1'b1;
    @(posedge PCLK); #1;
    m0_psel = 1'b1; m0_pwrite = 1'b0; m0_paddr = 16'h0004;
    for (int c = 0; c <= 10; c++) begin
      @(negedge PCLK);
      chk("t7_tmo_err", timeout_err, c == 10);
      chk("t7_tmo_pready", m0_pready, c == 10);
      if (c == 10) chk("t7_tmo_prdata", m0_prdata, 16'hFFFF);
    end
    @(posedge PCLK); #1; m0_psel = 1'b0; stall = 1'b0;
    @(negedge PCLK);
    // PREADY on the eighth ACCESS cycle wins over the limit.
    wait_n = 7;
    @(posedge PCLK); #1; m0_psel = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge PCLK);
      chk("t8_no_err", timeout_err, 1'b0);
      chk("t8_pready", m0_pready, c == 10);
      if (c == 10) chk("t8_prdata", m0_prdata, mm[4]);
    end
    @(posedge PCLK); #1; m0_psel = 1'b0;
    @(negedge PCLK);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
